// File: rtl/i2c_slave_responder_if.sv
// i2c_slave_responder_if: I2C pins plus the received-byte strobe bundle.
// Ports: scl_i/sda_i bus inputs, scl_o/sda_o open-drain drives (1 = released),
// rx_valid_o/rx_data_o/rx_ptr_o written-byte report, busy_o transaction flag.
interface i2c_slave_responder_if #(
    parameter int PTR_W = 4
);
    logic             scl_i, sda_i, scl_o, sda_o, rx_valid_o, busy_o;
    logic [7:0]       rx_data_o;
    logic [PTR_W-1:0] rx_ptr_o;
    modport slave  (input  scl_i, sda_i, output scl_o, sda_o, rx_valid_o, rx_data_o, rx_ptr_o, busy_o);
    modport master (output scl_i, sda_i, input  scl_o, sda_o, rx_valid_o, rx_data_o, rx_ptr_o, busy_o);
endinterface

// File: rtl/i2c_slave_responder.sv
// i2c_slave_responder: I2C target with a byte-addressed register file (EEPROM-style).
// Ports: clk_i, rst_n_i (async active-low); bus (slave modport) carries scl/sda in/out,
// the rx_valid_o/rx_data_o/rx_ptr_o strobe for each written byte, and busy_o.
// Macro I2C_SLV_GCALL_EN: also ACK general-call writes (address byte 8'h00).
module i2c_slave_responder #(
    parameter logic [6:0] I2C_ADDR  = 7'h22,
    parameter int         MEM_DEPTH = 16,
    parameter int         PTR_W     = $clog2(MEM_DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    i2c_slave_responder_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, RX_PTR, RX_DATA, TX_BYTE, TX_ACK, IGNORE} state_t;
    state_t           state_q, state_d;
    logic [1:0]       scl_sync_q, sda_sync_q;
    logic             scl_prev_q, sda_prev_q;
    logic [3:0]       cnt_q, cnt_d;
    logic [7:0]       sh_q, sh_d, rx_data_q, rx_data_d;
    logic [PTR_W-1:0] ptr_q, ptr_d, rx_ptr_q, rx_ptr_d;
    logic             sda_q, sda_d, rw_q, rw_d, gc_q, gc_d, busy_q, busy_d, rx_valid_q, rx_valid_d;
    logic [7:0]       mem_q [MEM_DEPTH];
    logic [7:0]       mem_d [MEM_DEPTH];
    logic             scl, sda, scl_rise, scl_fall, start, stop, match, gcall;
    logic [7:0]       byte_in;

    assign scl      = scl_sync_q[1];
    assign sda      = sda_sync_q[1];
    assign scl_rise = scl & ~scl_prev_q;
    assign scl_fall = ~scl & scl_prev_q;
    assign start    = scl & scl_prev_q & sda_prev_q & ~sda;
    assign stop     = scl & scl_prev_q & ~sda_prev_q & sda;
    assign byte_in  = {sh_q[6:0], sda};
    assign match    = byte_in[7:1] == I2C_ADDR;
`ifdef I2C_SLV_GCALL_EN
    assign gcall    = byte_in == 8'h00;
`else
    assign gcall    = 1'b0;
`endif

    // cnt: 0..8 counts bits of the current byte; 8 = ACK pending, 9 = ACK being driven
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sh_d       = sh_q;
        ptr_d      = ptr_q;
        sda_d      = sda_q;
        rw_d       = rw_q;
        gc_d       = gc_q;
        busy_d     = busy_q;
        rx_valid_d = 1'b0;
        rx_data_d  = rx_data_q;
        rx_ptr_d   = rx_ptr_q;
        mem_d      = mem_q;
        if (stop) begin
            state_d = IDLE;
            sda_d   = 1'b1;
            busy_d  = 1'b0;
        end else if (start) begin
            state_d = ADDR;
            cnt_d   = 4'd0;
            sda_d   = 1'b1;
            gc_d    = 1'b0;
        end else if (scl_rise && state_q inside {ADDR, RX_PTR, RX_DATA} && cnt_q < 4'd8) begin
            sh_d  = byte_in;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7 && state_q == ADDR) begin
                state_d = (match || gcall) ? ADDR_ACK : IGNORE;
                busy_d  = match || gcall;
                rw_d    = byte_in[0];
                gc_d    = gcall;
            end else if (cnt_q == 4'd7 && state_q == RX_PTR) begin
                ptr_d = byte_in[PTR_W-1:0];
            end else if (cnt_q == 4'd7) begin
                rx_valid_d = 1'b1;
                rx_data_d  = byte_in;
                rx_ptr_d   = gc_q ? '0 : ptr_q;
                if (!gc_q) begin
                    mem_d[ptr_q] = byte_in;
                    ptr_d        = ptr_q + 1'b1;
                end
            end
        end else if (scl_rise && state_q == TX_ACK) begin
            state_d = sda ? IGNORE : TX_BYTE;
            busy_d  = ~sda;
            cnt_d   = 4'd0;
        end else if (scl_fall && state_q inside {ADDR_ACK, RX_PTR, RX_DATA} && cnt_q == 4'd8) begin
            sda_d = 1'b0;
            cnt_d = 4'd9;
        end else if (scl_fall && ((state_q == ADDR_ACK && rw_q && cnt_q == 4'd9) || (state_q == TX_BYTE && cnt_q == 4'd0))) begin
            // load on the fall that ends the previous ACK so the MSB is on the bus immediately
            state_d = TX_BYTE;
            sh_d    = mem_q[ptr_q];
            sda_d   = mem_q[ptr_q][7];
            cnt_d   = 4'd1;
        end else if (scl_fall && state_q inside {ADDR_ACK, RX_PTR, RX_DATA} && cnt_q == 4'd9) begin
            state_d = (state_q == ADDR_ACK && !gc_q) ? RX_PTR : RX_DATA;
            sda_d   = 1'b1;
            cnt_d   = 4'd0;
        end else if (scl_fall && state_q == TX_BYTE && cnt_q < 4'd8) begin
            sh_d  = {sh_q[6:0], sh_q[7]};
            sda_d = sh_q[6];
            cnt_d = cnt_q + 4'd1;
        end else if (scl_fall && state_q == TX_BYTE) begin
            state_d = TX_ACK;
            sda_d   = 1'b1;
            ptr_d   = ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            sh_q       <= 8'h00;
            ptr_q      <= '0;
            sda_q      <= 1'b1;
            rw_q       <= 1'b0;
            gc_q       <= 1'b0;
            busy_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_ptr_q   <= '0;
            mem_q      <= '{default: 8'h00};
        end else begin
            scl_sync_q <= {scl_sync_q[0], bus.scl_i};
            sda_sync_q <= {sda_sync_q[0], bus.sda_i};
            scl_prev_q <= scl;
            sda_prev_q <= sda;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sh_q       <= sh_d;
            ptr_q      <= ptr_d;
            sda_q      <= sda_d;
            rw_q       <= rw_d;
            gc_q       <= gc_d;
            busy_q     <= busy_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            rx_ptr_q   <= rx_ptr_d;
            mem_q      <= mem_d;
        end
    end

    assign bus.scl_o      = 1'b1;
    assign bus.sda_o      = sda_q;
    assign bus.rx_valid_o = rx_valid_q;
    assign bus.rx_data_o  = rx_data_q;
    assign bus.rx_ptr_o   = rx_ptr_q;
    assign bus.busy_o     = busy_q;
endmodule

// File: tb/tb_i2c_slave_responder.sv
// tb_i2c_slave_responder: randomized I2C master driving the responder, checked against a memory model.
module tb_i2c_slave_responder;
    localparam int DEPTH = 16;
    localparam int PW    = 4;
    localparam int Q     = 8;
`ifdef I2C_SLV_GCALL_EN
    localparam bit GC_ON = 1'b1;
`else
    localparam bit GC_ON = 1'b0;
`endif
    logic clk = 1'b0, rst_n = 1'b0, scl_m = 1'b1, sda_m = 1'b1;
    int vecs = 0, errs = 0;
    logic [7:0]    mem_m [DEPTH];
    logic [PW-1:0] ptr_m;
    logic [PW+7:0] rx_q[$], exp_q[$];

    i2c_slave_responder_if #(.PTR_W(PW)) bus();
    i2c_slave_responder #(.I2C_ADDR(7'h22), .MEM_DEPTH(DEPTH)) dut (.clk_i(clk), .rst_n_i(rst_n), .bus(bus));

    assign bus.scl_i = scl_m & bus.scl_o;
    assign bus.sda_i = sda_m & bus.sda_o;
    always #5 clk = ~clk;
    always @(negedge clk) if (bus.rx_valid_o) rx_q.push_back({bus.rx_ptr_o, bus.rx_data_o});

    task automatic quarter();
        repeat (Q) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; quarter();
        scl_m = 1'b1; quarter();
        sda_m = 1'b0; quarter();
        scl_m = 1'b0; quarter();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; quarter();
        scl_m = 1'b1; quarter();
        sda_m = 1'b1; quarter();
    endtask

    task automatic clk_bit(input logic b, output logic s);
        sda_m = b; quarter();
        scl_m = 1'b1; quarter();
        s = bus.sda_i; quarter();
        scl_m = 1'b0; quarter();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(d[i], s);
        clk_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(1'b1, d[i]);
        clk_bit(nack, s);
    endtask

    task automatic wr_xfer(input logic [7:0] p, input logic [7:0] d[$], output int nacks);
        logic a;
        nacks = 0;
        i2c_start();
        write_byte(8'h44, a); nacks += int'(a);
        write_byte(p, a);     nacks += int'(a);
        foreach (d[i]) begin
            write_byte(d[i], a);
            nacks += int'(a);
        end
    endtask

    task automatic rd_xfer(input logic set_ptr, input logic [7:0] p, input int n, output logic [7:0] d[$], output int nacks);
        logic a;
        logic [7:0] b;
        nacks = 0;
        d = {};
        i2c_start();
        if (set_ptr) begin
            write_byte(8'h44, a); nacks += int'(a);
            write_byte(p, a);     nacks += int'(a);
            i2c_start();
        end
        write_byte(8'h45, a); nacks += int'(a);
        for (int i = 0; i < n; i++) begin
            read_byte(i == n - 1, b);
            d.push_back(b);
        end
    endtask

    function automatic void model_wr(input logic [7:0] p, input logic [7:0] d[$]);
        ptr_m = p[PW-1:0];
        foreach (d[i]) begin
            exp_q.push_back({ptr_m, d[i]});
            mem_m[ptr_m] = d[i];
            ptr_m++;
        end
    endfunction

    function automatic void model_rd(input logic set_ptr, input logic [7:0] p, input int n, output logic [7:0] d[$]);
        d = {};
        if (set_ptr) ptr_m = p[PW-1:0];
        for (int i = 0; i < n; i++) begin
            d.push_back(mem_m[ptr_m]);
            ptr_m++;
        end
    endfunction

    task automatic test_reset();
        vecs++; if (bus.sda_o !== 1'b1) begin errs++; $display("FAIL reset_sda: got %b want 1", bus.sda_o); end
        vecs++; if (bus.scl_o !== 1'b1) begin errs++; $display("FAIL reset_scl: got %b want 1", bus.scl_o); end
        vecs++; if (bus.rx_valid_o !== 1'b0) begin errs++; $display("FAIL reset_rx_valid: got %b want 0", bus.rx_valid_o); end
        vecs++; if (bus.rx_data_o !== 8'h00) begin errs++; $display("FAIL reset_rx_data: got %h want 00", bus.rx_data_o); end
        vecs++; if (bus.rx_ptr_o !== 4'h0) begin errs++; $display("FAIL reset_rx_ptr: got %h want 0", bus.rx_ptr_o); end
        vecs++; if (bus.busy_o !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", bus.busy_o); end
    endtask

    task automatic test_write();
        logic a;
        int nacks = 0;
        logic [7:0] d[$] = '{8'h10, 8'h11, 8'h12, 8'h13};
        i2c_start();
        write_byte(8'h44, a); nacks += int'(a);
        vecs++; if (bus.busy_o !== 1'b1) begin errs++; $display("FAIL write_busy: got %b want 1", bus.busy_o); end
        write_byte(8'h00, a); nacks += int'(a);
        foreach (d[i]) begin write_byte(d[i], a); nacks += int'(a); end
        i2c_stop();
        model_wr(8'h00, d);
        vecs++; if (nacks !== 0) begin errs++; $display("FAIL write_acks: got %0d nacks want 0", nacks); end
        vecs++; if (bus.busy_o !== 1'b0) begin errs++; $display("FAIL write_busy_stop: got %b want 0", bus.busy_o); end
        vecs++; if (rx_q.size() != exp_q.size()) begin errs++; $display("FAIL write_rx_count: got %0d want %0d", rx_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            vecs++; if (rx_q[i] !== exp_q[i]) begin errs++; $display("FAIL write_rx%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
        end
        rx_q.delete(); exp_q.delete();
    endtask

    task automatic test_read();
        logic [7:0] got[$], exp[$];
        int nacks;
        rd_xfer(1'b1, 8'h00, 4, got, nacks);
        model_rd(1'b1, 8'h00, 4, exp);
        vecs++; if (bus.sda_o !== 1'b1) begin errs++; $display("FAIL read_release: got %b want 1", bus.sda_o); end
        vecs++; if (bus.busy_o !== 1'b0) begin errs++; $display("FAIL read_busy_nack: got %b want 0", bus.busy_o); end
        i2c_stop();
        vecs++; if (nacks !== 0) begin errs++; $display("FAIL read_acks: got %0d nacks want 0", nacks); end
        foreach (exp[i]) begin
            vecs++; if (got[i] !== exp[i]) begin errs++; $display("FAIL read_byte%0d: got %h want %h", i, got[i], exp[i]); end
        end
    endtask

    task automatic test_wrong_addr();
        logic a;
        i2c_start();
        write_byte(8'h46, a);
        vecs++; if (a !== 1'b1) begin errs++; $display("FAIL wrong_addr_ack: got %b want 1", a); end
        vecs++; if (bus.busy_o !== 1'b0) begin errs++; $display("FAIL wrong_addr_busy: got %b want 0", bus.busy_o); end
        write_byte(8'hAA, a);
        vecs++; if (a !== 1'b1) begin errs++; $display("FAIL wrong_addr_data_ack: got %b want 1", a); end
        i2c_stop();
        vecs++; if (rx_q.size() != 0) begin errs++; $display("FAIL wrong_addr_rx: got %0d pulses want 0", rx_q.size()); end
        rx_q.delete();
    endtask

    task automatic test_wrap();
        logic [7:0] d[$] = '{8'hA0, 8'hA1};
        logic [7:0] got[$], exp[$];
        int nacks;
        wr_xfer(8'h0F, d, nacks);
        i2c_stop();
        model_wr(8'h0F, d);
        vecs++; if (nacks !== 0) begin errs++; $display("FAIL wrap_acks: got %0d nacks want 0", nacks); end
        vecs++; if (rx_q.size() != exp_q.size()) begin errs++; $display("FAIL wrap_rx_count: got %0d want %0d", rx_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            vecs++; if (rx_q[i] !== exp_q[i]) begin errs++; $display("FAIL wrap_rx%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
        end
        rx_q.delete(); exp_q.delete();
        rd_xfer(1'b1, 8'h0E, 4, got, nacks);
        i2c_stop();
        model_rd(1'b1, 8'h0E, 4, exp);
        foreach (exp[i]) begin
            vecs++; if (got[i] !== exp[i]) begin errs++; $display("FAIL wrap_read%0d: got %h want %h", i, got[i], exp[i]); end
        end
    endtask

    task automatic test_random();
        logic [7:0] d[$], got[$], exp[$];
        logic [7:0] p;
        logic cur;
        int nacks, n;
        for (int k = 0; k < 5; k++) begin
            p = 8'($urandom);
            d = {};
            n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++) d.push_back(8'($urandom));
            wr_xfer(p, d, nacks);
            i2c_stop();
            model_wr(p, d);
            vecs++; if (nacks !== 0) begin errs++; $display("FAIL rand%0d_wr_acks: got %0d want 0", k, nacks); end
            vecs++; if (rx_q.size() != exp_q.size()) begin errs++; $display("FAIL rand%0d_rx_count: got %0d want %0d", k, rx_q.size(), exp_q.size()); end
            else foreach (exp_q[i]) begin
                vecs++; if (rx_q[i] !== exp_q[i]) begin errs++; $display("FAIL rand%0d_rx%0d: got %h want %h", k, i, rx_q[i], exp_q[i]); end
            end
            rx_q.delete(); exp_q.delete();
            cur = 1'($urandom);
            p = 8'($urandom);
            n = $urandom_range(1, 4);
            rd_xfer(!cur, p, n, got, nacks);
            i2c_stop();
            model_rd(!cur, p, n, exp);
            vecs++; if (nacks !== 0) begin errs++; $display("FAIL rand%0d_rd_acks: got %0d want 0", k, nacks); end
            foreach (exp[i]) begin
                vecs++; if (got[i] !== exp[i]) begin errs++; $display("FAIL rand%0d_rd%0d: got %h want %h", k, i, got[i], exp[i]); end
            end
        end
    endtask

    task automatic test_stop_mid();
        logic a, s;
        logic [7:0] p = 8'($urandom);
        logic [7:0] got[$], exp[$];
        int nacks = 0;
        i2c_start();
        write_byte(8'h44, a); nacks += int'(a);
        write_byte(p, a);     nacks += int'(a);
        for (int i = 0; i < 4; i++) clk_bit(1'($urandom), s);
        i2c_stop();
        ptr_m = p[PW-1:0];
        vecs++; if (nacks !== 0) begin errs++; $display("FAIL stop_mid_acks: got %0d want 0", nacks); end
        vecs++; if (rx_q.size() != 0) begin errs++; $display("FAIL stop_mid_rx: got %0d pulses want 0", rx_q.size()); end
        vecs++; if (bus.busy_o !== 1'b0) begin errs++; $display("FAIL stop_mid_busy: got %b want 0", bus.busy_o); end
        rx_q.delete();
        rd_xfer(1'b0, 8'h00, 2, got, nacks);
        i2c_stop();
        model_rd(1'b0, 8'h00, 2, exp);
        foreach (exp[i]) begin
            vecs++; if (got[i] !== exp[i]) begin errs++; $display("FAIL stop_mid_read%0d: got %h want %h", i, got[i], exp[i]); end
        end
    endtask

    task automatic test_reset_mid();
        logic a, s;
        logic [7:0] got[$], exp[$];
        logic [7:0] d[$];
        logic [7:0] p;
        int nacks;
        i2c_start();
        write_byte(8'h44, a);
        write_byte(8'h05, a);
        write_byte(8'h77, a);
        for (int i = 0; i < 3; i++) clk_bit(1'($urandom), s);
        sda_m = 1'($urandom); quarter();
        scl_m = 1'b1; quarter();
        rst_n = 1'b0;
        #1;
        vecs++; if (bus.sda_o !== 1'b1) begin errs++; $display("FAIL reset_mid_sda: got %b want 1", bus.sda_o); end
        vecs++; if (bus.busy_o !== 1'b0) begin errs++; $display("FAIL reset_mid_busy: got %b want 0", bus.busy_o); end
        scl_m = 1'b1; sda_m = 1'b1;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;
        quarter();
        foreach (mem_m[i]) mem_m[i] = 8'h00;
        ptr_m = '0;
        rx_q.delete();
        rd_xfer(1'b1, 8'h00, DEPTH, got, nacks);
        i2c_stop();
        model_rd(1'b1, 8'h00, DEPTH, exp);
        vecs++; if (nacks !== 0) begin errs++; $display("FAIL reset_mid_rd_acks: got %0d want 0", nacks); end
        foreach (exp[i]) begin
            vecs++; if (got[i] !== exp[i]) begin errs++; $display("FAIL reset_mid_mem%0d: got %h want %h", i, got[i], exp[i]); end
        end
        p = 8'($urandom);
        d = '{8'($urandom), 8'($urandom), 8'($urandom)};
        wr_xfer(p, d, nacks);
        i2c_stop();
        model_wr(p, d);
        vecs++; if (nacks !== 0) begin errs++; $display("FAIL reset_mid_wr_acks: got %0d want 0", nacks); end
        vecs++; if (rx_q.size() != exp_q.size()) begin errs++; $display("FAIL reset_mid_rx_count: got %0d want %0d", rx_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            vecs++; if (rx_q[i] !== exp_q[i]) begin errs++; $display("FAIL reset_mid_rx%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
        end
        rx_q.delete(); exp_q.delete();
        rd_xfer(1'b1, p, 3, got, nacks);
        i2c_stop();
        model_rd(1'b1, p, 3, exp);
        foreach (exp[i]) begin
            vecs++; if (got[i] !== exp[i]) begin errs++; $display("FAIL reset_mid_read%0d: got %h want %h", i, got[i], exp[i]); end
        end
    endtask

    task automatic test_gcall();
        logic a;
        logic [7:0] got[$], exp[$];
        int nacks;
        i2c_start();
        write_byte(8'h00, a);
        vecs++; if (a !== !GC_ON) begin errs++; $display("FAIL gcall_addr_ack: got %b want %b", a, !GC_ON); end
        write_byte(8'h5A, a);
        vecs++; if (a !== !GC_ON) begin errs++; $display("FAIL gcall_data_ack: got %b want %b", a, !GC_ON); end
        i2c_stop();
        if (GC_ON) exp_q.push_back({4'h0, 8'h5A});
        vecs++; if (rx_q.size() != exp_q.size()) begin errs++; $display("FAIL gcall_rx_count: got %0d want %0d", rx_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            vecs++; if (rx_q[i] !== exp_q[i]) begin errs++; $display("FAIL gcall_rx%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
        end
        rx_q.delete(); exp_q.delete();
        rd_xfer(1'b0, 8'h00, 2, got, nacks);
        i2c_stop();
        model_rd(1'b0, 8'h00, 2, exp);
        foreach (exp[i]) begin
            vecs++; if (got[i] !== exp[i]) begin errs++; $display("FAIL gcall_read%0d: got %h want %h", i, got[i], exp[i]); end
        end
    endtask

    initial begin
        foreach (mem_m[i]) mem_m[i] = 8'h00;
        ptr_m = '0;
        rst_n = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        quarter();
        test_write();
        test_read();
        test_wrong_addr();
        test_wrap();
        test_random();
        test_stop_mid();
        test_gcall();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
